// File: rtl/rx_packet_pkg.sv
// rx_packet_pkg: shared state enum, ASCII constants and header field layout for rx_packet
package rx_packet_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_TERM, DISCARD} state_t;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_UF = 8'h46;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LF = 8'h66;
  localparam int HDR_W      = 64;
  localparam int TICK_LSB   = 0;
  localparam int TICK_W     = 16;
  localparam int FLAGS_LSB  = 16;
  localparam int FLAGS_W    = 4;
  localparam int LAGX_LSB   = 20;
  localparam int LAGX_W     = 8;
  localparam int LAGA_LSB   = 28;
  localparam int LAGA_W     = 8;
  localparam int DELAY_LSB  = 36;
  localparam int DELAY_W    = 12;
  localparam int INPUTS_LSB = 48;
  localparam int INPUTS_W   = 8;
  localparam int RES_LSB    = 56;
  localparam int RES_W      = 8;
endpackage

// File: rtl/hex_nibble_decode.sv
// hex_nibble_decode: combinational ASCII hex digit to nibble converter
//   data   : received byte
//   nibble : decoded value (0 when not a hex digit)
//   is_hex : byte is '0'-'9', 'A'-'F' or 'a'-'f'
module hex_nibble_decode
  import rx_packet_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       is_hex
);
  logic dig, alpha;
  always_comb begin
    dig    = data >= CH_0 && data <= CH_9;
    alpha  = (data >= CH_UA && data <= CH_UF) || (data >= CH_LA && data <= CH_LF);
    is_hex = dig || alpha;
    nibble = dig ? data[3:0] : alpha ? data[3:0] + 4'd9 : 4'd0;
  end
endmodule

// File: rtl/rx_packet.sv
// rx_packet: assembles a nibble stream (ASCII hex or binary) into fixed-size packets
//   sysclk, reset         : clock and synchronous active-high reset
//   rx_data, rx_valid     : incoming byte and its one-cycle strobe
//   packet, packet_valid  : last complete packet and its update pulse
//   frame_error, busy     : framing fault pulse, state-not-idle flag
//   hdr_*                 : header fields, live only with RX_PACKET_HEADER_DECODE_EN defined
module rx_packet
  import rx_packet_pkg::*;
#(
  parameter int PACKET_SIZE    = 192,
  parameter int BINARY         = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [PACKET_SIZE-1:0] packet,
  output logic                   packet_valid,
  output logic                   frame_error,
  output logic                   busy,
  output logic [15:0]            hdr_tick,
  output logic [3:0]             hdr_flags,
  output logic [7:0]             hdr_lag_cross,
  output logic [7:0]             hdr_lag_auto,
  output logic [11:0]            hdr_delay,
  output logic [7:0]             hdr_inputs,
  output logic [7:0]             hdr_resolution
);
  localparam int TOTAL_NIBBLES = PACKET_SIZE / 4;
  localparam int CW = $clog2(TOTAL_NIBBLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HB = PACKET_SIZE - HDR_W;
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL_NIBBLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
`ifdef RX_PACKET_HEADER_DECODE_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PACKET_SIZE-1:0] shreg_q, shreg_d, packet_q, packet_d, shifted;
  logic pv_q, pv_d, fe_q, fe_d;
  logic [3:0] dec_nib, nib;
  logic dec_hex, hex, is_cr, done, err, res_bad;
  hex_nibble_decode u_dec (.data(rx_data), .nibble(dec_nib), .is_hex(dec_hex));
  assign nib     = BINARY != 0 ? rx_data[3:0] : dec_nib;
  assign hex     = BINARY != 0 ? 1'b1 : dec_hex;
  assign is_cr   = BINARY == 0 && rx_data == CR;
  assign shifted = {shreg_q[PACKET_SIZE-5:0], nib};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = '0;
    shreg_d = shreg_q;
    done    = 1'b0;
    err     = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE: if (hex) begin
          shreg_d = shifted;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
        COLLECT: if (hex) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          done    = BINARY != 0 && cnt_d == TOTAL_C;
          state_d = cnt_d != TOTAL_C ? COLLECT : BINARY != 0 ? IDLE : WAIT_TERM;
        end else begin
          err     = 1'b1;
          state_d = is_cr ? IDLE : DISCARD;
        end
        WAIT_TERM: begin
          done    = is_cr;
          err     = !is_cr;
          state_d = is_cr ? IDLE : DISCARD;
        end
        DISCARD: state_d = is_cr ? IDLE : DISCARD;
        default: state_d = IDLE;
      endcase
    end else if (state_q == COLLECT || state_q == WAIT_TERM) begin
      err     = timer_q == TMAX;
      timer_d = err ? '0 : timer_q + TW'(1);
      state_d = err ? IDLE : state_q;
    end
    // a completed packet with a zero resolution field is rejected when header decode is enabled
    res_bad  = HDR_EN && shreg_d[HB+RES_LSB +: RES_W] == '0;
    pv_d     = done && !res_bad;
    fe_d     = err || (done && res_bad);
    packet_d = pv_d ? shreg_d : packet_q;
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      shreg_q  <= '0;
      packet_q <= '0;
      pv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      shreg_q  <= shreg_d;
      packet_q <= packet_d;
      pv_q     <= pv_d;
      fe_q     <= fe_d;
    end
  end
  assign packet         = packet_q;
  assign packet_valid   = pv_q;
  assign frame_error    = fe_q;
  assign busy           = state_q != IDLE;
  assign hdr_tick       = HDR_EN ? packet_q[HB+TICK_LSB +: TICK_W] : '0;
  assign hdr_flags      = HDR_EN ? packet_q[HB+FLAGS_LSB +: FLAGS_W] : '0;
  assign hdr_lag_cross  = HDR_EN ? packet_q[HB+LAGX_LSB +: LAGX_W] : '0;
  assign hdr_lag_auto   = HDR_EN ? packet_q[HB+LAGA_LSB +: LAGA_W] : '0;
  assign hdr_delay      = HDR_EN ? packet_q[HB+DELAY_LSB +: DELAY_W] : '0;
  assign hdr_inputs     = HDR_EN ? packet_q[HB+INPUTS_LSB +: INPUTS_W] : '0;
  assign hdr_resolution = HDR_EN ? packet_q[HB+RES_LSB +: RES_W] : '0;
endmodule

// File: doc/rx_packet.md
RX_PACKET -- requirements
Module: rx_packet

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 192: bits per packet; it SHALL be a multiple of 4 and at least 128.
REQ-002 SHALL have parameter BINARY, default 0: 0 = ASCII-hex byte stream, 1 = binary nibble stream.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle gap between bytes inside a packet, in sysclk cycles.
REQ-004 SHALL have port sysclk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port rx_data, input, 8: received byte.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port packet, output, PACKET_SIZE: last complete packet.
REQ-009 SHALL have port packet_valid, output, 1: one-cycle pulse when packet updates.
REQ-010 SHALL have port frame_error, output, 1: one-cycle pulse on any framing fault.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-012 SHALL have ports hdr_tick (16), hdr_flags (4), hdr_lag_cross (8), hdr_lag_auto (8), hdr_delay (12), hdr_inputs (8) and hdr_resolution (8), all outputs: decoded header fields.

Function
REQ-013 SHALL accept 1 nibble per rx_valid; TOTAL_NIBBLES = PACKET_SIZE/4.
REQ-014 The first nibble SHALL land in packet[PACKET_SIZE-1 -: 4]; assembly is shift-left-by-4 with insertion at the LSBs.
REQ-015 ASCII mode SHALL accept '0'-'9', 'A'-'F' and 'a'-'f' as hex digits; 0x0D is the terminator.
REQ-016 Binary mode SHALL take rx_data[3:0] as the nibble and SHALL use no terminator.
REQ-017 The state machine SHALL have states IDLE, COLLECT, WAIT_TERM and DISCARD.
REQ-018 IDLE: a hex digit SHALL load nibble 1 and go to COLLECT; any other byte SHALL be ignored.
REQ-019 COLLECT: a hex digit SHALL increment the nibble count; at count == TOTAL_NIBBLES it SHALL go to WAIT_TERM in ASCII mode, or complete in binary mode.
REQ-020 COLLECT, ASCII: an early 0x0D SHALL pulse frame_error and go to IDLE; any other non-hex byte SHALL pulse frame_error and go to DISCARD.
REQ-021 WAIT_TERM: 0x0D SHALL complete the packet; any other byte SHALL pulse frame_error and go to DISCARD.
REQ-022 DISCARD: the state SHALL remain DISCARD until 0x0D, then go to IDLE with no further error pulse.
REQ-023 On completion, packet and the hdr_* outputs SHALL update and packet_valid SHALL pulse in the cycle after the completing rx_valid, then the state returns to IDLE.
REQ-024 packet SHALL hold its value between completions; partial or errored frames SHALL never alter it.
REQ-025 In COLLECT or WAIT_TERM, a gap of TIMEOUT_CYCLES with no rx_valid SHALL pulse frame_error and go to IDLE.
REQ-026 If rx_valid arrives in the same cycle the timer expires, the byte SHALL win: the timer clears and the byte is processed.
REQ-027 Header mapping (header = packet[PACKET_SIZE-1 -: 64], offsets from the header LSB): tick [15:0], flags [19:16], lag_cross [27:20], lag_auto [35:28], delay [47:36], inputs [55:48], resolution [63:56].
REQ-028 The footer timestamp SHALL be packet[63:0]; the payload SHALL be the bits between footer and header.

Reset
REQ-029 Reset SHALL force IDLE, clear the nibble count and timer, and zero packet, packet_valid, frame_error, busy and all hdr_* outputs.
REQ-030 Reset asserted mid-packet SHALL discard the partial frame with no frame_error pulse.

Configuration
REQ-031 With macro RX_PACKET_HEADER_DECODE_EN defined, the hdr_* outputs SHALL be registered per REQ-023 and REQ-027, and a completed packet whose hdr_resolution is 0 SHALL pulse frame_error instead of packet_valid, leaving packet unchanged.
REQ-032 Without RX_PACKET_HEADER_DECODE_EN, the hdr_* ports SHALL exist, be tied to 0, and no resolution check is performed.

Structure
REQ-033 Package rx_packet_pkg SHALL hold the state enum, the ASCII constants (CR = 0x0D, digit and letter bounds), and the header field offsets and widths.
REQ-034 Sub-module hex_nibble_decode SHALL be combinational: byte in, nibble[3:0] and is_hex out.
REQ-035 Timer and nibble-count widths SHALL be $clog2-derived from TIMEOUT_CYCLES and TOTAL_NIBBLES.

Verification
REQ-036 ASCII, PACKET_SIZE=192, bytes "0123456789ABCDEF" repeated 3 times then 0x0D -> packet = 0x0123...CDEF (x3), packet_valid pulses once 1 cycle after CR, frame_error stays 0.
REQ-037 Send 20 hex digits then 0x0D -> frame_error pulses once, packet unchanged, state IDLE, busy 0.
REQ-038 Send 10 digits, then 'G', 'X', 0x0D, then a valid frame -> one frame_error, DISCARD until CR, then the valid frame is accepted.
REQ-039 TIMEOUT_CYCLES=100: 5 digits then 100 idle cycles -> frame_error pulse and IDLE; repeat with rx_valid exactly at cycle 100 -> no error and the count advances.
REQ-040 Assert reset after 30 digits -> all outputs 0; a subsequent full frame decodes correctly.
REQ-041 With RX_PACKET_HEADER_DECODE_EN and header resolution field = 0x18, hdr_resolution = 24 and hdr_tick matches bits [15:0] of the header; with resolution field = 0x00, frame_error pulses instead of packet_valid.
